// File: rtl/pck_pkg.sv
// Shared types and helpers for the pck socket FIFO.
package pck_pkg;

   typedef struct packed {
      int unsigned data_width;
      int unsigned depth;
      int unsigned afull_thr;
   } fifo_cfg_t;

   // Occupancy needs one bit more than the pointers so that "full" is representable.
   function automatic int unsigned cnt_width(int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/pck_fifo_ram.sv
// Simple dual-port storage array with one write port and a registered read port.
module pck_fifo_ram #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned DEPTH      = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       we,
   input  logic [$clog2(DEPTH)-1:0]   waddr,
   input  logic [DATA_WIDTH-1:0]      wdata,
   input  logic                       re,
   input  logic [$clog2(DEPTH)-1:0]   raddr,
   output logic [DATA_WIDTH-1:0]      rdata
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // Array itself is never reset; only the read register is.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/pck_socket_fifo.sv
// Synchronous FIFO with one-cycle read latency, full/almost-full/empty flags and occupancy.
// Optional sticky overflow/underflow flags are built when PCK_FIFO_ERR_EN is defined.
module pck_socket_fifo
   import pck_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned DEPTH      = 16,
   parameter int unsigned AFULL_THR  = DEPTH - 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [DATA_WIDTH-1:0]        s_data,
   input  logic                         s_dv,
   output logic                         s_full,
   output logic                         s_afull,
   input  logic                         m_rd_en,
   output logic [DATA_WIDTH-1:0]        m_data,
   output logic                         m_dv,
   output logic                         m_empty,
   output logic [cnt_width(DEPTH)-1:0]  count,
   output logic                         err_ovf,
   output logic                         err_udf
);

   localparam fifo_cfg_t Cfg = '{data_width: DATA_WIDTH, depth: DEPTH, afull_thr: AFULL_THR};
   localparam int unsigned AW = $clog2(Cfg.depth);
   localparam int unsigned CW = cnt_width(Cfg.depth);

   logic [AW-1:0] wptr_q, wptr_d;
   logic [AW-1:0] rptr_q, rptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          m_dv_q;
   logic          wr_acc, rd_acc;

   // Flags decode from registered occupancy only.
   assign s_full  = (count_q == CW'(Cfg.depth));
   assign s_afull = (count_q >= CW'(Cfg.afull_thr));
   assign m_empty = (count_q == '0);
   assign count   = count_q;
   assign m_dv    = m_dv_q;

   assign wr_acc = s_dv & ~s_full;
   assign rd_acc = m_rd_en & ~m_empty;

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (wr_acc) begin
         wptr_d = wptr_q + AW'(1);
      end
      if (rd_acc) begin
         rptr_d = rptr_q + AW'(1);
      end
      unique case ({wr_acc, rd_acc})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         m_dv_q  <= 1'b0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         m_dv_q  <= rd_acc;
      end
   end

   // Read/write addresses never collide: a simultaneous pair implies 0 < count < DEPTH.
   pck_fifo_ram #(
      .DATA_WIDTH (Cfg.data_width),
      .DEPTH      (Cfg.depth)
   ) u_ram (
      .clk   (clk),
      .rst   (rst),
      .we    (wr_acc & ~rst),
      .waddr (wptr_q),
      .wdata (s_data),
      .re    (rd_acc & ~rst),
      .raddr (rptr_q),
      .rdata (m_data)
   );

`ifdef PCK_FIFO_ERR_EN
   logic err_ovf_q, err_udf_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         err_ovf_q <= 1'b0;
         err_udf_q <= 1'b0;
      end else begin
         if (s_dv && s_full) begin
            err_ovf_q <= 1'b1;
         end
         if (m_rd_en && m_empty) begin
            err_udf_q <= 1'b1;
         end
      end
   end

   assign err_ovf = err_ovf_q;
   assign err_udf = err_udf_q;
`else
   assign err_ovf = 1'b0;
   assign err_udf = 1'b0;
`endif

endmodule

// File: doc/pck_socket_fifo.md
PCK_SOCKET_FIFO -- requirements
Module: pck_socket_fifo

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8: payload width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 16: storage entries; a power of two, at least 4.
REQ-003 The block SHALL have parameter AFULL_THR, default DEPTH-2: occupancy at or above which s_afull asserts; range 1..DEPTH.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port s_data, input, DATA_WIDTH bits: write payload from the producer.
REQ-007 The block SHALL have port s_dv, input, 1 bit: write strobe; s_data is sampled when s_dv is high.
REQ-008 The block SHALL have port s_full, output, 1 bit: high when count equals DEPTH.
REQ-009 The block SHALL have port s_afull, output, 1 bit: high when count is at least AFULL_THR.
REQ-010 The block SHALL have port m_rd_en, input, 1 bit: read request from the consumer.
REQ-011 The block SHALL have port m_data, output, DATA_WIDTH bits: read payload.
REQ-012 The block SHALL have port m_dv, output, 1 bit: m_data is valid this cycle.
REQ-013 The block SHALL have port m_empty, output, 1 bit: high when count equals 0.
REQ-014 The block SHALL have port count, output, $clog2(DEPTH)+1 bits: current occupancy.
REQ-015 The block SHALL have ports err_ovf and err_udf, outputs, 1 bit each: sticky overflow and underflow flags.

Function
REQ-016 A write SHALL be accepted when s_dv=1 and s_full=0; s_data is stored at the write pointer, and the write pointer increments modulo DEPTH.
REQ-017 A read SHALL be accepted when m_rd_en=1 and m_empty=0; the entry at the read pointer is registered onto m_data, m_dv=1 on the next cycle, and the read pointer increments modulo DEPTH.
REQ-018 Read latency SHALL be exactly 1 cycle; m_dv SHALL be 0 on every cycle that does not follow an accepted read, and m_data SHALL hold its last value.
REQ-019 s_full, s_afull, m_empty and count SHALL be decoded from registered state only, with no combinational path from s_dv or m_rd_en.
REQ-020 Simultaneous accepted write and read SHALL leave count unchanged and advance both pointers.
REQ-021 When full, a simultaneous s_dv and m_rd_en SHALL accept the read and drop the write.
REQ-022 When empty, a simultaneous s_dv and m_rd_en SHALL accept the write and ignore the read; m_empty falls on the next cycle.
REQ-023 A dropped write SHALL not alter storage, pointers or count; a rejected read SHALL not alter pointers or count.
REQ-024 Data order SHALL be strictly FIFO across pointer wrap-around.

Reset
REQ-025 While rst=1, pointers SHALL be 0, count 0, m_dv 0, m_data 0, m_empty 1, s_full 0, s_afull 0, err_ovf 0 and err_udf 0.
REQ-026 Reset asserted mid-stream SHALL discard all stored entries; s_dv and m_rd_en SHALL be ignored during reset; storage contents need not be cleared.

Configuration
REQ-027 When macro PCK_FIFO_ERR_EN is defined, err_ovf SHALL set on any cycle with s_dv=1 and a dropped write, and err_udf SHALL set on any cycle with m_rd_en=1 and m_empty=1; both SHALL clear only on rst.
REQ-028 When PCK_FIFO_ERR_EN is undefined, err_ovf and err_udf SHALL be tied to 0, and no detection logic SHALL be synthesised.

Structure
REQ-029 Package pck_pkg SHALL hold a typedef struct for the fifo parameter set (DATA_WIDTH, DEPTH, AFULL_THR) and a function for count width.
REQ-030 Storage SHALL be the sub-module pck_fifo_ram: a simple dual-port array with a synchronous read port; pointer and flag logic SHALL stay in pck_socket_fifo.

Verification
REQ-031 After reset with DEPTH=16, write 0x01..0x10 -> s_full=1 and count=16; s_afull rises when count reaches 14.
REQ-032 From full, issue 16 reads -> m_data is 0x01..0x10 in order, each 1 cycle after its m_rd_en; m_empty=1 afterwards.
REQ-033 Stream 40 writes with concurrent reads at count=8 -> count stays 8 and the output order is intact across two pointer wraps.
REQ-034 At full, issue s_dv=1 with data 0xAA and no read -> data is dropped, count stays 16, and err_ovf=1 with PCK_FIFO_ERR_EN (0 without it).
REQ-035 At empty, issue m_rd_en=1 -> m_dv stays 0 and err_udf=1 with PCK_FIFO_ERR_EN; issuing s_dv and m_rd_en together -> count=1 on the next cycle.
REQ-036 Assert rst at count=5 -> on the next cycle count=0, m_empty=1, the flags are clear, and the next write/read returns the new data.
